// File: rtl/bcd_pkg.sv
// Shared BCD digit type, digit limits and load-value clamp.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  function automatic bcd_digit_t bcd_clamp(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one StepPulse every TICK_DIV enabled cycles of CLOCK_50.
module tick_gen #(
  parameter int TICK_DIV = 50000000,
  parameter int PRE_W    = $clog2(TICK_DIV)
) (
  input  logic CLOCK_50,
  input  logic Clear,
  input  logic Enable,
  input  logic Restart,
  output logic StepPulse
);

  localparam logic [PRE_W-1:0] TERM = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;

  assign StepPulse = Enable && (pre == TERM);

  always_ff @(posedge CLOCK_50) begin
    if (Clear || Restart) begin
      pre <= '0;
    end else if (Enable) begin
      pre <= (pre == TERM) ? '0 : pre + PRE_W'(1);
    end
  end

endmodule

// File: rtl/bcd_counter_nd.sv
// Multi-digit BCD up/down counter with prescaler, parallel load and tick/wrap flags.
// Define BCD_COUNTER_SATURATE_EN to hold at all-9s/all-0s instead of rolling over.
module bcd_counter_nd
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000000,
  parameter int PRE_W      = $clog2(TICK_DIV)
) (
  input  logic                    CLOCK_50,
  input  logic                    Clear,
  input  logic                    Enable,
  input  logic                    Up,
  input  logic                    Load,
  input  logic [4*NUM_DIGITS-1:0] LoadValue,
  output logic [4*NUM_DIGITS-1:0] Count,
  output logic                    Tick,
  output logic                    Wrap,
  output logic                    Zero
);

  logic                step;
  logic                hold_step;
  logic [NUM_DIGITS:0] carry;

  tick_gen #(
    .TICK_DIV (TICK_DIV),
    .PRE_W    (PRE_W)
  ) u_tick_gen (
    .CLOCK_50  (CLOCK_50),
    .Clear     (Clear),
    .Enable    (Enable),
    .Restart   (Load),
    .StepPulse (step)
  );

  // carry[k]: every digit below k sits at its limit, so digit k moves on a step
  assign carry[0] = 1'b1;

`ifdef BCD_COUNTER_SATURATE_EN
  assign hold_step = carry[NUM_DIGITS];
`else
  assign hold_step = 1'b0;
`endif

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    bcd_digit_t d;
    bcd_digit_t d_next;

    assign carry[k+1] = carry[k] & (Up ? (d == BCD_MAX) : (d == BCD_MIN));

    always_comb begin
      d_next = d;
      if (carry[k]) begin
        if (Up) d_next = (d == BCD_MAX) ? BCD_MIN : d + 4'd1;
        else    d_next = (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
      end
    end

    always_ff @(posedge CLOCK_50) begin
      if (Clear) begin
        d <= BCD_MIN;
      end else if (Load) begin
        d <= bcd_clamp(LoadValue[4*k +: 4]);
      end else if (step && !hold_step) begin
        d <= d_next;
      end
    end

    assign Count[4*k +: 4] = d;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Clear || Load) begin
      Tick <= 1'b0;
      Wrap <= 1'b0;
    end else begin
      Tick <= step;
      Wrap <= step & carry[NUM_DIGITS];
    end
  end

  assign Zero = (Count == '0);

endmodule
